fetch_unit: RTL and testbench

Front-end pipeline stage that generates sequential instruction addresses, issues word-read requests to instruction memory, and buffers in-order responses. Presents one instruction per cycle to the decode stage as insn_valid / insn_addr / insn.
Supports a redirect (branch/exception) that flushes the buffer and discards in-flight responses, and a stall from decode that holds the output.

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, word-read requests to imem, in-order response buffer.
// Latency: a response in cycle N is presented to decode in cycle N+2 (empty buffer, no stall).
// Backpressure: stall freezes the output registers; requests stop once the buffer is full or in-flight hits BUF_DEPTH.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   redirect_valid/addr   restart fetch at a new word address; flushes buffer, drops in-flight responses
//   stall                 decode cannot accept; insn_valid/insn_addr/insn hold their values
//   mem_req_*             read request channel (valid/ready), word address
//   mem_rsp_*             in-order read data, never backpressured
//   insn_valid/addr/insn  registered instruction handed to decode

module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 'h0,
    parameter int                    BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-3:0] redirect_addr,
    input  logic                  stall,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  insn_valid,
    output logic [ADDR_WIDTH-3:0] insn_addr,
    output logic [31:0]           insn
);

    localparam int AW = ADDR_WIDTH - 2;
    localparam int PW = $clog2(BUF_DEPTH);

    // Depth expressed at pointer width and at one bit wider for sums.
    localparam logic [PW:0]   DEPTH_P = (PW + 1)'(BUF_DEPTH);
    localparam logic [PW+1:0] DEPTH_X = (PW + 2)'(BUF_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]        pc;
    logic [PW:0]          alloc_ptr;
    logic [PW:0]          fill_ptr;
    logic [PW:0]          head_ptr;
    logic [PW:0]          drop_cnt;
    logic [BUF_DEPTH-1:0] filled;
    entry_t               buf_mem [BUF_DEPTH];

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [PW-1:0] alloc_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] head_idx;
    logic [PW:0]   used;
    logic [PW:0]   outstanding;
    logic [PW+1:0] inflight;
    logic [PW+1:0] redir_sum;
    logic          full;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          head_rdy;
    logic          pop;

    assign alloc_idx   = alloc_ptr[PW-1:0];
    assign fill_idx    = fill_ptr[PW-1:0];
    assign head_idx    = head_ptr[PW-1:0];

    // Wrap-bit pointers: differences are exact occupancy counts.
    assign used        = alloc_ptr - head_ptr;
    assign outstanding = alloc_ptr - fill_ptr;
    assign full        = (used == DEPTH_P);

    // Old-stream responses still owed plus current-stream requests not yet
    // answered; capping this at the depth keeps drop_cnt bounded.
    assign inflight    = {1'b0, drop_cnt} + {1'b0, outstanding};

    assign mem_req_valid = !rst && !full && !redirect_valid && (inflight < DEPTH_X);
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response in a redirect cycle is always discarded; the redirect
    // drop count below already accounts for it.
    assign rsp_drop = mem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    // The filled bit of a slot can be stale once popped, so the head is only
    // trusted while it lies inside the allocated window.
    assign head_rdy = (head_ptr != alloc_ptr) && filled[head_idx];
    assign pop      = !redirect_valid && !stall && head_rdy;

    // Everything still owed by memory becomes droppable on redirect. The
    // request term is zero in practice (redirect blocks mem_req_valid) but
    // keeps the count correct if that gating ever changes.
    assign redir_sum = {1'b0, drop_cnt} + {1'b0, outstanding}
                     + (PW + 2)'(req_fire) - (PW + 2)'(mem_rsp_valid);

    // ------------------------------------------------------------------
    // PC, pointers, drop counter, filled flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_ADDR[ADDR_WIDTH-1:2];
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_addr;
            fill_ptr  <= alloc_ptr;
            head_ptr  <= alloc_ptr;
            drop_cnt  <= redir_sum[PW:0];
            filled    <= '0;
        end else begin
            if (req_fire) begin
                pc                <= pc + AW'(1);
                alloc_ptr         <= alloc_ptr + (PW + 1)'(1);
                filled[alloc_idx] <= 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - (PW + 1)'(1);
            end
            if (rsp_fill) begin
                fill_ptr         <= fill_ptr + (PW + 1)'(1);
                filled[fill_idx] <= 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + (PW + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: payload only, validity lives in the pointers/flags.
    // Allocation and fill never target the same slot in one cycle because
    // a fill always refers to an already-allocated entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (req_fire) begin
            buf_mem[alloc_idx].addr <= pc;
        end
        if (rsp_fill) begin
            buf_mem[fill_idx].data <= mem_rsp_data;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: redirect > stall > load head > idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn_valid <= 1'b0;
            insn_addr  <= '0;
            insn       <= '0;
        end else if (redirect_valid) begin
            insn_valid <= 1'b0;
        end else if (stall) begin
            insn_valid <= insn_valid;
        end else if (head_rdy) begin
            insn_valid <= 1'b1;
            insn_addr  <= buf_mem[head_idx].addr;
            insn       <= buf_mem[head_idx].data;
        end else begin
            insn_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus a scoreboard of expected instructions.
// Latency: memory answers one cycle after a request unless responses are held back.
// Backpressure: bench drives stall, mem_req_ready and a response hold to exercise the buffer limits.

module tb_fetch_unit;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          stall;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          insn_valid;
    logic [AW-1:0] insn_addr;
    logic [31:0]   insn;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_ADDR (32'h100),
        .BUF_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .insn_valid     (insn_valid),
        .insn_addr      (insn_addr),
        .insn           (insn)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          exp_q [$];
    logic [AW-1:0] pend  [$];
    logic [AW-1:0] exp_pc;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            first_hs;
    int            first_vld;
    int            vld_cnt;
    bit            rsp_hold;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_data;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock cycle: drive the memory response, sample at negedge, return at posedge+1.
    task automatic cycle();
        exp_t          e;
        logic [AW-1:0] a;
        if (!rsp_hold && pend.size() > 0) begin
            a             = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(a);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        @(negedge clk);
        if (redirect_valid) begin
            chk("req_in_redirect", mem_req_valid, 0);
            exp_q.delete();
            exp_pc = redirect_addr;
        end else if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, exp_pc);
            pend.push_back(mem_req_addr);
            e = '{addr: exp_pc, data: mem_word(exp_pc)};
            exp_q.push_back(e);
            exp_pc = exp_pc + 1'b1;
            if (first_hs < 0) first_hs = cyc;
        end
        if (insn_valid) begin
            if (first_vld < 0) first_vld = cyc;
            vld_cnt++;
        end
        if (insn_valid && !stall && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_insn", insn_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("insn_addr", insn_addr, e.addr);
                chk("insn_data", insn, e.data);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Stop requesting, let every owed response and instruction drain (bounded).
    task automatic drain(input string tag);
        mem_req_ready  = 1'b0;
        stall          = 1'b0;
        rsp_hold       = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || pend.size() != 0); i++) cycle();
        cycle();
        cycle();
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_pend"}, pend.size(), 0);
        chk({tag, "_idle"}, insn_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        stall          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        rsp_hold       = 1'b0;
        exp_pc         = 30'h40;
        first_hs       = -1;
        first_vld      = -1;
        vld_cnt        = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_insn_valid", insn_valid, 0);
        chk("rst_insn_addr", insn_addr, 0);
        chk("rst_insn", insn, 0);
        chk("rst_req_valid", mem_req_valid, 0);

        // Sequential fetch from RESET_ADDR, one-cycle memory
        rst           = 1'b0;
        mem_req_ready = 1'b1;
        cyc           = 0;
        repeat (8) cycle();
        chk("first_latency", first_vld - first_hs, 3);
        vld_cnt = 0;
        repeat (20) cycle();
        chk("throughput", vld_cnt, 20);

        // Stall mid-stream: outputs frozen, requests stop once buffer is full
        stall  = 1'b1;
        h_addr = insn_addr;
        h_data = insn;
        repeat (6) cycle();
        chk("stall_hold_valid", insn_valid, 1);
        chk("stall_hold_addr", insn_addr, h_addr);
        chk("stall_hold_data", insn, h_data);
        chk("stall_req_off", mem_req_valid, 0);
        stall = 1'b0;
        repeat (10) cycle();
        drain("stall");

        // Redirect with three requests in flight
        rsp_hold      = 1'b1;
        mem_req_ready = 1'b1;
        repeat (3) cycle();
        mem_req_ready = 1'b0;
        chk("inflight_before_redirect", pend.size(), 3);
        redirect_valid = 1'b1;
        redirect_addr  = 30'h200;
        cycle();
        redirect_valid = 1'b0;
        rsp_hold       = 1'b0;
        mem_req_ready  = 1'b1;
        repeat (12) cycle();
        drain("redir");

        // Redirect coinciding with a response, then back-to-back redirect
        rsp_hold      = 1'b1;
        mem_req_ready = 1'b1;
        repeat (2) cycle();
        mem_req_ready  = 1'b0;
        rsp_hold       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 30'h300;
        cycle();
        redirect_addr  = 30'h380;
        cycle();
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        repeat (10) cycle();
        drain("redir2");

        // PC wrap at the top of the word-address space
        redirect_valid = 1'b1;
        redirect_addr  = 30'h3FFF_FFFF;
        mem_req_ready  = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        drain("wrap");

        // Asynchronous reset mid-stream with stall and outstanding requests
        mem_req_ready = 1'b1;
        repeat (6) cycle();
        stall    = 1'b1;
        rsp_hold = 1'b1;
        repeat (2) cycle();
        chk("pre_rst_valid", insn_valid, 1);
        chk("pre_rst_outstanding", pend.size() >= 2, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_insn_valid", insn_valid, 0);
        chk("async_rst_insn_addr", insn_addr, 0);
        chk("async_rst_insn", insn, 0);
        chk("async_rst_req_valid", mem_req_valid, 0);
        pend.delete();
        exp_q.delete();
        exp_pc        = 30'h40;
        rsp_hold      = 1'b0;
        stall         = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        first_hs  = -1;
        first_vld = -1;
        cyc       = 0;
        repeat (8) cycle();
        chk("restart_latency", first_vld - first_hs, 3);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
